// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the MEM pipeline stage and its
// data-memory request controller.
package mem_stage_pkg;

   localparam int CTRL_WB_W    = 3;
   localparam int CM_REG_WRITE = 4;
   localparam int CM_WB_SEL_HI = 3;
   localparam int CM_WB_SEL_LO = 2;
   localparam int CM_MEM_READ  = 1;
   localparam int CM_MEM_WRITE = 0;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10
   } wb_sel_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   function automatic logic [CTRL_WB_W-1:0] ctrl_to_wb(input logic [4:0] ctrl);
      return {ctrl[CM_REG_WRITE], ctrl[CM_WB_SEL_HI:CM_WB_SEL_LO]};
   endfunction

   function automatic logic ctrl_is_access(input logic [4:0] ctrl);
      return ctrl[CM_MEM_READ] | ctrl[CM_MEM_WRITE];
   endfunction

endpackage

// File: rtl/mem_stage_req_fsm.sv
// Data-memory request controller: issues one req/ack access at a time,
// bounds the wait with a timeout and raises sticky misalign/timeout errors.
module mem_req_fsm
   import mem_stage_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           ctrl_mem,
   input  logic [DATA_W-1:0]    rd_mem,
   input  logic [DATA_W-1:0]    alu_result,
   input  logic [DATA_W-1:0]    write_data1,
   input  logic [DATA_W-1:0]    pc4_mem,
   input  logic                 dmem_ack,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [DATA_W-1:0]    dmem_addr,
   output logic [DATA_W-1:0]    dmem_wdata,
   output logic                 stall,
   output logic                 err_misalign,
   output logic                 err_timeout,
   output logic                 wb_pass,
   output logic                 wb_done,
   output logic [CTRL_WB_W-1:0] cap_ctrl_wb,
   output logic [DATA_W-1:0]    cap_rd,
   output logic [DATA_W-1:0]    cap_pc4
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic [DATA_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [CTRL_WB_W-1:0]   ctrl_q, ctrl_d;
   logic [DATA_W-1:0]      rd_q, rd_d;
   logic [DATA_W-1:0]      pc4_q, pc4_d;
   logic                   err_mis_q, err_mis_d;
   logic                   err_to_q, err_to_d;

   logic access, aligned, issue, last;

   assign access  = ctrl_is_access(ctrl_mem);
   assign aligned = (alu_result[1:0] == 2'b00);
   assign last    = (cnt_q == CNT_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ctrl_d    = ctrl_q;
      rd_d      = rd_q;
      pc4_d     = pc4_q;
      err_mis_d = err_mis_q;
      err_to_d  = err_to_q;
      issue     = 1'b0;
      wb_pass   = 1'b0;
      wb_done   = 1'b0;
      stall     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!access) begin
               wb_pass = 1'b1;
            end else if (!aligned) begin
               err_mis_d = 1'b1;
            end else begin
               issue   = 1'b1;
               state_d = WAIT;
               cnt_d   = '0;
               // both read and write set is treated as a store
               we_d    = ctrl_mem[CM_MEM_WRITE];
               addr_d  = alu_result;
               wdata_d = write_data1;
               ctrl_d  = ctrl_to_wb(ctrl_mem);
               rd_d    = rd_mem;
               pc4_d   = pc4_mem;
            end
         end
         WAIT: begin
            if (dmem_ack) begin
               wb_done = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else if (last) begin
               err_to_d = 1'b1;
               state_d  = IDLE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      stall = issue | ((state_q == WAIT) & ~dmem_ack & ~last);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ctrl_q    <= '0;
         rd_q      <= '0;
         pc4_q     <= '0;
         err_mis_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ctrl_q    <= ctrl_d;
         rd_q      <= rd_d;
         pc4_q     <= pc4_d;
         err_mis_q <= err_mis_d;
         err_to_q  <= err_to_d;
      end
   end

   assign dmem_req     = (state_q == WAIT);
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign err_misalign = err_mis_q;
   assign err_timeout  = err_to_q;
   assign cap_ctrl_wb  = ctrl_q;
   assign cap_rd       = rd_q;
   assign cap_pc4      = pc4_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory access through mem_req_fsm and the
// MEM/WB pipeline register fed by either pass-through or completed access.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           ctrl_mem,
   input  logic [DATA_W-1:0]    rd_mem,
   input  logic [DATA_W-1:0]    alu_result,
   input  logic [DATA_W-1:0]    write_data1,
   input  logic [DATA_W-1:0]    pc4_mem,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [DATA_W-1:0]    dmem_addr,
   output logic [DATA_W-1:0]    dmem_wdata,
   input  logic                 dmem_ack,
   input  logic [DATA_W-1:0]    dmem_rdata,
   output logic                 stall,
   output logic                 err_misalign,
   output logic                 err_timeout,
   output logic [CTRL_WB_W-1:0] ctrl_wb,
   output logic [DATA_W-1:0]    rd_wb,
   output logic [DATA_W-1:0]    alu_result_wb,
   output logic [DATA_W-1:0]    read_data_wb,
   output logic [DATA_W-1:0]    pc4_wb
);

   logic                 wb_pass, wb_done;
   logic [CTRL_WB_W-1:0] cap_ctrl_wb;
   logic [DATA_W-1:0]    cap_rd, cap_pc4;

   logic [CTRL_WB_W-1:0] ctrl_wb_q, ctrl_wb_d;
   logic [DATA_W-1:0]    rd_wb_q, rd_wb_d;
   logic [DATA_W-1:0]    alu_wb_q, alu_wb_d;
   logic [DATA_W-1:0]    rdata_wb_q, rdata_wb_d;
   logic [DATA_W-1:0]    pc4_wb_q, pc4_wb_d;

   mem_req_fsm #(
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_req_fsm (
      .clk          (clk),
      .reset        (reset),
      .ctrl_mem     (ctrl_mem),
      .rd_mem       (rd_mem),
      .alu_result   (alu_result),
      .write_data1  (write_data1),
      .pc4_mem      (pc4_mem),
      .dmem_ack     (dmem_ack),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .stall        (stall),
      .err_misalign (err_misalign),
      .err_timeout  (err_timeout),
      .wb_pass      (wb_pass),
      .wb_done      (wb_done),
      .cap_ctrl_wb  (cap_ctrl_wb),
      .cap_rd       (cap_rd),
      .cap_pc4      (cap_pc4)
   );

   // Anything that is neither a pass-through nor a completed access is a bubble.
   always_comb begin
      ctrl_wb_d  = '0;
      rd_wb_d    = rd_wb_q;
      alu_wb_d   = alu_wb_q;
      rdata_wb_d = rdata_wb_q;
      pc4_wb_d   = pc4_wb_q;
      if (wb_pass) begin
         ctrl_wb_d  = ctrl_to_wb(ctrl_mem);
         rd_wb_d    = rd_mem;
         alu_wb_d   = alu_result;
         rdata_wb_d = '0;
         pc4_wb_d   = pc4_mem;
      end else if (wb_done) begin
         ctrl_wb_d  = cap_ctrl_wb;
         rd_wb_d    = cap_rd;
         alu_wb_d   = dmem_addr;
         rdata_wb_d = dmem_we ? '0 : dmem_rdata;
         pc4_wb_d   = cap_pc4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_wb_q  <= '0;
         rd_wb_q    <= '0;
         alu_wb_q   <= '0;
         rdata_wb_q <= '0;
         pc4_wb_q   <= '0;
      end else begin
         ctrl_wb_q  <= ctrl_wb_d;
         rd_wb_q    <= rd_wb_d;
         alu_wb_q   <= alu_wb_d;
         rdata_wb_q <= rdata_wb_d;
         pc4_wb_q   <= pc4_wb_d;
      end
   end

   assign ctrl_wb       = ctrl_wb_q;
   assign rd_wb         = rd_wb_q;
   assign alu_result_wb = alu_wb_q;
   assign read_data_wb  = rdata_wb_q;
   assign pc4_wb        = pc4_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: each instruction's expected timeline
// (issue, wait, ack or timeout) is derived from its ack delay.
module tb_mem_stage;

   localparam int unsigned TO = 4;

   logic        clk;
   logic        reset;
   logic [4:0]  ctrl_mem;
   logic [31:0] rd_mem, alu_result, write_data1, pc4_mem;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall, err_misalign, err_timeout;
   logic [2:0]  ctrl_wb;
   logic [31:0] rd_wb, alu_result_wb, read_data_wb, pc4_wb;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   logic        exp_mis = 1'b0;
   logic        exp_to  = 1'b0;

   mem_stage #(
      .DATA_W         (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ctrl_mem      (ctrl_mem),
      .rd_mem        (rd_mem),
      .alu_result    (alu_result),
      .write_data1   (write_data1),
      .pc4_mem       (pc4_mem),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_ack      (dmem_ack),
      .dmem_rdata    (dmem_rdata),
      .stall         (stall),
      .err_misalign  (err_misalign),
      .err_timeout   (err_timeout),
      .ctrl_wb       (ctrl_wb),
      .rd_wb         (rd_wb),
      .alu_result_wb (alu_result_wb),
      .read_data_wb  (read_data_wb),
      .pc4_wb        (pc4_wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no-finish required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_errs();
      check("err_misalign", {31'b0, err_misalign}, {31'b0, exp_mis});
      check("err_timeout", {31'b0, err_timeout}, {31'b0, exp_to});
   endtask

   // ack_dly: index of the request cycle that sees dmem_ack; >= TO means never.
   task automatic run_instr(input logic [4:0] c, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input logic [31:0] pc4,
                            input int unsigned ack_dly, input logic [31:0] rdata,
                            input logic idle_ack);
      logic acc, alg, st;
      acc = c[1] | c[0];
      alg = (a[1:0] == 2'b00);
      st  = c[0];
      ctrl_mem    = c;
      alu_result  = a;
      write_data1 = wd;
      rd_mem      = rd;
      pc4_mem     = pc4;
      dmem_ack    = idle_ack;
      dmem_rdata  = $urandom;
      #1;
      check("stall_idle", {31'b0, stall}, {31'b0, acc & alg});
      step();
      if (!acc) begin
         check("pass_ctrl", {29'b0, ctrl_wb}, {29'b0, c[4], c[3:2]});
         check("pass_rd", rd_wb, rd);
         check("pass_alu", alu_result_wb, a);
         check("pass_rdata", read_data_wb, 32'h0);
         check("pass_pc4", pc4_wb, pc4);
         check("pass_req", {31'b0, dmem_req}, 32'h0);
      end else if (!alg) begin
         exp_mis = 1'b1;
         check("mis_ctrl", {29'b0, ctrl_wb}, 32'h0);
         check("mis_req", {31'b0, dmem_req}, 32'h0);
      end else begin
         check("issue_bubble", {29'b0, ctrl_wb}, 32'h0);
         for (int unsigned j = 0; j < TO; j++) begin
            check("req_high", {31'b0, dmem_req}, 32'h1);
            check("req_we", {31'b0, dmem_we}, {31'b0, st});
            check("req_addr", dmem_addr, a);
            check("req_wdata", dmem_wdata, wd);
            ctrl_mem    = 5'($urandom);
            alu_result  = $urandom;
            write_data1 = $urandom;
            rd_mem      = $urandom;
            pc4_mem     = $urandom;
            if (j == ack_dly) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rdata;
               #1;
               check("stall_ack", {31'b0, stall}, 32'h0);
               step();
               dmem_ack = 1'b0;
               check("done_ctrl", {29'b0, ctrl_wb}, {29'b0, c[4], c[3:2]});
               check("done_rd", rd_wb, rd);
               check("done_alu", alu_result_wb, a);
               check("done_rdata", read_data_wb, st ? 32'h0 : rdata);
               check("done_pc4", pc4_wb, pc4);
               check("done_req", {31'b0, dmem_req}, 32'h0);
               break;
            end else begin
               dmem_ack = 1'b0;
               #1;
               check("stall_wait", {31'b0, stall}, {31'b0, j != TO - 1});
               step();
               if (j == TO - 1) begin
                  exp_to = 1'b1;
                  check("to_req", {31'b0, dmem_req}, 32'h0);
                  check("to_bubble", {29'b0, ctrl_wb}, 32'h0);
               end
            end
         end
      end
      check_errs();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"}, {31'b0, dmem_req}, 32'h0);
      check({tag, "_stall"}, {31'b0, stall}, 32'h0);
      check({tag, "_we"}, {31'b0, dmem_we}, 32'h0);
      check({tag, "_addr"}, dmem_addr, 32'h0);
      check({tag, "_wdata"}, dmem_wdata, 32'h0);
      check({tag, "_ctrl"}, {29'b0, ctrl_wb}, 32'h0);
      check({tag, "_rd"}, rd_wb, 32'h0);
      check({tag, "_alu"}, alu_result_wb, 32'h0);
      check({tag, "_rdata"}, read_data_wb, 32'h0);
      check({tag, "_pc4"}, pc4_wb, 32'h0);
      check_errs();
   endtask

   task automatic random_instr();
      logic [4:0]  c;
      logic [31:0] a;
      int unsigned m;
      c[4]   = 1'($urandom_range(0, 1));
      c[3:2] = 2'($urandom_range(0, 2));
      m      = $urandom_range(0, 9);
      c[1:0] = (m < 4) ? 2'b00 : (m < 7) ? 2'b10 : (m < 9) ? 2'b01 : 2'b11;
      a      = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      run_instr(c, a, $urandom, $urandom, $urandom, $urandom_range(0, TO + 1), $urandom,
                1'($urandom_range(0, 3) == 0));
   endtask

   initial begin
      reset       = 1'b1;
      ctrl_mem    = '0;
      rd_mem      = '0;
      alu_result  = '0;
      write_data1 = '0;
      pc4_mem     = '0;
      dmem_ack    = 1'b0;
      dmem_rdata  = '0;
      step();
      step();
      check_all_zero("rst");
      reset = 1'b0;

      run_instr(5'b1_00_00, 32'h1234, 32'h0, 32'h5, 32'h2000, 0, 32'h0, 1'b0);
      run_instr(5'b1_01_10, 32'h100, 32'h0, 32'h7, 32'h3000, 2, 32'hDEADBEEF, 1'b0);
      run_instr(5'b0_00_01, 32'h40, 32'hA5A5, 32'h0, 32'h3004, 0, 32'h0, 1'b0);
      run_instr(5'b1_01_10, 32'h102, 32'h0, 32'h9, 32'h3008, 0, 32'h0, 1'b0);
      run_instr(5'b1_01_10, 32'h200, 32'h0, 32'hA, 32'h300C, TO, 32'h0, 1'b0);
      run_instr(5'b1_01_10, 32'h204, 32'h0, 32'hB, 32'h3010, TO - 1, 32'h0BADF00D, 1'b0);
      run_instr(5'b1_10_00, 32'h8, 32'h0, 32'hC, 32'h3014, 0, 32'h0, 1'b1);

      for (int i = 0; i < 300; i++) random_instr();

      ctrl_mem   = 5'b1_01_10;
      alu_result = 32'h300;
      rd_mem     = 32'h1F;
      pc4_mem    = 32'h4000;
      dmem_ack   = 1'b0;
      step();
      check("rw_req", {31'b0, dmem_req}, 32'h1);
      reset       = 1'b1;
      ctrl_mem    = '0;
      alu_result  = '0;
      rd_mem      = '0;
      pc4_mem     = '0;
      write_data1 = '0;
      step();
      exp_mis = 1'b0;
      exp_to  = 1'b0;
      check_all_zero("rst_wait");
      reset = 1'b0;

      for (int i = 0; i < 20; i++) random_instr();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
